// File: rtl/fround_pipe.sv
// -----------------------------------------------------------------------------
// fround_pipe
//   Two-stage elastic normalize / round / pack pipeline for one IEEE-754
//   binary format. It accepts an unnormalized sign / exponent / magnitude from
//   any FP producer (fma, divsqrt, cvt). It returns the packed result together
//   with the {NV,DZ,OF,UF,NX} flags. A sticky fflags accumulator is provided
//   for the CSR unit.
//
//   Stage 1 : leading-zero count, normalize or denormalize, extract the kept
//             bits plus the guard and sticky bits.
//   Stage 2 : round, detect overflow and tininess, apply special-value
//             overrides, then pack. The stage-2 register drives the outputs.
//
// Parameters
//   NE    exponent field width (bias = 2^(NE-1)-1 is implicit in InE)
//   NF    fraction field width
//   MW    input magnitude width, must be >= NF+3
//   TAGW  opaque tag width
//
// Ports
//   clk, resetn           clock, synchronous active-low reset
//   Flush                 drops every in-flight op and the op offered this cycle
//   InValid/InReady       input handshake; InReady is combinational from OutReady
//   InS, InE, InM         sign, signed biased exponent (NE+2 bits), magnitude
//   InSticky              OR of the low bits the producer discarded
//   InKind                00 finite, 01 zero, 10 inf, 11 NaN
//   InNV, InDZ            producer flags, passed through for every kind
//   InFrm                 rounding mode: RNE, RTZ, RDN, RUP, RMM
//   InTag                 carried alongside the data
//   OutValid/OutReady     output handshake; data is held while stalled
//   OutRes, OutFlg, OutTag  packed result, {NV,DZ,OF,UF,NX}, tag
//   FlgClr, AccFlg        accumulator clear and sticky OR of flags that transferred
// -----------------------------------------------------------------------------
module fround_pipe #(
    parameter int NE   = 8,
    parameter int NF   = 23,
    parameter int MW   = 32,
    parameter int TAGW = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               Flush,
    input  logic               InValid,
    output logic               InReady,
    input  logic               InS,
    input  logic [NE+1:0]      InE,
    input  logic [MW-1:0]      InM,
    input  logic               InSticky,
    input  logic [1:0]         InKind,
    input  logic               InNV,
    input  logic               InDZ,
    input  logic [2:0]         InFrm,
    input  logic [TAGW-1:0]    InTag,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [NE+NF:0]     OutRes,
    output logic [4:0]         OutFlg,
    output logic [TAGW-1:0]    OutTag,
    input  logic               FlgClr,
    output logic [4:0]         AccFlg
);

    localparam int LW = $clog2(MW + 1);       // lzc range 0..MW
    localparam int EW = NE + 2 + LW;          // InE minus lzc never overflows this
    localparam int GB = MW - NF - 2;          // guard-bit index in the aligned magnitude

    localparam logic [2:0] FRM_RNE = 3'b000;
    localparam logic [2:0] FRM_RTZ = 3'b001;
    localparam logic [2:0] FRM_RDN = 3'b010;
    localparam logic [2:0] FRM_RUP = 3'b011;
    localparam logic [2:0] FRM_RMM = 3'b100;

    localparam logic [1:0] KIND_FIN  = 2'b00;
    localparam logic [1:0] KIND_ZERO = 2'b01;
    localparam logic [1:0] KIND_INF  = 2'b10;

    // Round-increment decision, shared by the real rounding and by the
    // unbounded-exponent rounding that decides tininess.
    function automatic logic roundUp(input logic [2:0] frm, input logic s,
                                     input logic l, input logic g, input logic st);
        logic up;
        case (frm)
            FRM_RNE: up = g & (st | l);
            FRM_RTZ: up = 1'b0;
            FRM_RDN: up = s & (g | st);
            FRM_RUP: up = ~s & (g | st);
            FRM_RMM: up = g;
            default: up = 1'b0;
        endcase
        return up;
    endfunction

    // ---------------------------------------------------------------- handshake
    logic s1Valid;
    logic s2Valid;
    logic s2Free;
    logic s1Free;
    logic accFire;

    assign s2Free   = ~s2Valid | OutReady;
    assign s1Free   = ~s1Valid | s2Free;
    assign InReady  = s1Free;
    assign OutValid = s2Valid;
    // A flushed cycle is not a transfer, so it never reaches the accumulator.
    assign accFire  = s2Valid & OutReady & ~Flush;

    // ---------------------------------------------------------------- stage 1
    // zeroAbove[i] is set when InM[MW-1:i] is all zero. The single set bit
    // of lead marks the leading one.
    logic [MW:0]   zeroAbove;
    logic [MW-1:0] lead;

    assign zeroAbove[MW] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < MW; gi++) begin : g_lzc
            assign zeroAbove[gi] = zeroAbove[gi+1] & ~InM[gi];
            assign lead[gi]      = InM[gi] & zeroAbove[gi+1];
        end
    endgenerate

    logic [LW-1:0]        lzc;
    logic signed [EW-1:0] inEx;
    logic signed [EW-1:0] me;
    logic signed [EW-1:0] lsh;
    logic signed [EW-1:0] rsh;
    logic [MW-1:0]        norm;
    logic [MW-1:0]        shifted;
    logic [MW-1:0]        lostMask;
    logic                 shOut;
    logic [EW-1:0]        eS1;
    logic                 subS1;
    logic [NF:0]          keptS1;
    logic                 gS1;
    logic                 stS1;
    logic                 nAllS1;
    logic                 nGS1;
    logic                 nStS1;

    always_comb begin
        lzc = zeroAbove[0] ? LW'(MW) : '0;
        for (int i = 0; i < MW; i++) begin
            if (lead[i]) begin
                lzc = lzc | LW'(MW - 1 - i);
            end
        end
    end

    always_comb begin
        inEx     = {{(EW-NE-2){InE[NE+1]}}, InE};
        me       = inEx - EW'(lzc);
        lsh      = inEx - EW'(1);
        rsh      = EW'(1) - inEx;
        norm     = InM << lzc;
        shifted  = norm;
        lostMask = '0;
        shOut    = 1'b0;
        eS1      = me;
        subS1    = 1'b0;

        if (me > 0) begin
            shifted = norm;
        end else begin
            // Subnormal: align so that bit MW-1 carries weight 2^(1-bias).
            subS1 = 1'b1;
            eS1   = EW'(1);
            if (inEx > 0) begin
                // Here InE-1 < lzc, so no set bit leaves the top.
                shifted = InM << lsh;
            end else if (rsh >= EW'(MW)) begin
                shifted = '0;
                shOut   = |InM;
            end else begin
                shifted  = InM >> rsh;
                lostMask = ~({MW{1'b1}} << rsh);
                shOut    = |(InM & lostMask);
            end
        end

        keptS1 = shifted[MW-1 -: NF+1];
        gS1    = shifted[GB];
        stS1   = (|shifted[GB-1:0]) | shOut | InSticky;

        // An exponent of 0 before denormalizing is the only case where
        // rounding at full precision can reach 2^(1-bias). Keep the
        // normalized rounding inputs for that tininess check.
        nAllS1 = (me == 0) & (&norm[MW-1 -: NF+1]);
        nGS1   = norm[GB];
        nStS1  = (|norm[GB-1:0]) | InSticky;
    end

    logic              s1S;
    logic [EW-1:0]     s1E;
    logic              s1Sub;
    logic [NF:0]       s1Kept;
    logic              s1G;
    logic              s1St;
    logic              s1NAll;
    logic              s1NG;
    logic              s1NSt;
    logic [2:0]        s1Frm;
    logic [1:0]        s1Kind;
    logic              s1NV;
    logic              s1DZ;
    logic [TAGW-1:0]   s1Tag;

    // ---------------------------------------------------------------- stage 2
    logic              plus1;
    logic [NF+1:0]     sum;
    logic [NF:0]       mant;
    logic [EW-1:0]     expR;
    logic              of;
    logic              nx;
    logic              tiny;
    logic              uf;
    logic              ovInf;
    logic [NE-1:0]     expField;
    logic [NE+NF:0]    resS2;
    logic [4:0]        flgS2;

    always_comb begin
        plus1 = roundUp(s1Frm, s1S, s1Kept[0], s1G, s1St);
        sum   = {1'b0, s1Kept} + (NF+2)'(plus1);
        if (sum[NF+1]) begin
            // The mantissa carried out, so renormalize by one place.
            mant = sum[NF+1:1];
            expR = s1E + EW'(1);
        end else begin
            mant = sum[NF:0];
            expR = s1E;
        end

        of    = ~s1Sub & (expR >= EW'(2**NE - 1));
        nx    = s1G | s1St | of;
        tiny  = s1Sub & ~(s1NAll & roundUp(s1Frm, s1S, 1'b1, s1NG, s1NSt));
        uf    = nx & tiny;
        ovInf = (s1Frm == FRM_RNE) | (s1Frm == FRM_RMM) |
                ((s1Frm == FRM_RUP) & ~s1S) | ((s1Frm == FRM_RDN) & s1S);

        // A subnormal keeps hidden bit 0 unless rounding carried into it.
        // In that case the stored exponent of 1 becomes the true field.
        expField = mant[NF] ? expR[NE-1:0] : '0;

        if (of) begin
            resS2 = ovInf ? {s1S, {NE{1'b1}}, {NF{1'b0}}}
                          : {s1S, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};
        end else begin
            resS2 = {s1S, expField, mant[NF-1:0]};
        end
        flgS2 = {s1NV, s1DZ, of, uf, nx};

        // Special values bypass rounding and raise only the producer flags.
        if (s1Kind != KIND_FIN) begin
            flgS2 = {s1NV, s1DZ, 3'b000};
            if (s1Kind == KIND_ZERO) begin
                resS2 = {s1S, {(NE+NF){1'b0}}};
            end else if (s1Kind == KIND_INF) begin
                resS2 = {s1S, {NE{1'b1}}, {NF{1'b0}}};
            end else begin
                resS2 = {1'b0, {NE{1'b1}}, 1'b1, {(NF-1){1'b0}}};
            end
        end
    end

    logic [NE+NF:0]    s2Res;
    logic [4:0]        s2Flg;
    logic [TAGW-1:0]   s2Tag;
    logic [4:0]        accFlg;

    assign OutRes = s2Res;
    assign OutFlg = s2Flg;
    assign OutTag = s2Tag;
    assign AccFlg = accFlg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1Valid <= 1'b0;
            s2Valid <= 1'b0;
            s1S     <= 1'b0;
            s1E     <= '0;
            s1Sub   <= 1'b0;
            s1Kept  <= '0;
            s1G     <= 1'b0;
            s1St    <= 1'b0;
            s1NAll  <= 1'b0;
            s1NG    <= 1'b0;
            s1NSt   <= 1'b0;
            s1Frm   <= '0;
            s1Kind  <= '0;
            s1NV    <= 1'b0;
            s1DZ    <= 1'b0;
            s1Tag   <= '0;
            s2Res   <= '0;
            s2Flg   <= '0;
            s2Tag   <= '0;
            accFlg  <= '0;
        end else begin
            if (Flush) begin
                s1Valid <= 1'b0;
                s2Valid <= 1'b0;
            end else begin
                if (s2Free) begin
                    s2Valid <= s1Valid;
                    if (s1Valid) begin
                        s2Res <= resS2;
                        s2Flg <= flgS2;
                        s2Tag <= s1Tag;
                    end
                end
                if (s1Free) begin
                    s1Valid <= InValid;
                    if (InValid) begin
                        s1S    <= InS;
                        s1E    <= eS1;
                        s1Sub  <= subS1;
                        s1Kept <= keptS1;
                        s1G    <= gS1;
                        s1St   <= stS1;
                        s1NAll <= nAllS1;
                        s1NG   <= nGS1;
                        s1NSt  <= nStS1;
                        s1Frm  <= InFrm;
                        s1Kind <= InKind;
                        s1NV   <= InNV;
                        s1DZ   <= InDZ;
                        s1Tag  <= InTag;
                    end
                end
            end

            // When a clear coincides with a transfer, that transfer's flags survive.
            if (FlgClr) begin
                accFlg <= accFire ? s2Flg : 5'b00000;
            end else if (accFire) begin
                accFlg <= accFlg | s2Flg;
            end
        end
    end

endmodule

// File: tb/tb_fround_pipe.sv
module tb_fround_pipe;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic        InS;
    logic [9:0]  InE;
    logic [31:0] InM;
    logic        InSticky;
    logic [1:0]  InKind;
    logic        InNV;
    logic        InDZ;
    logic [2:0]  InFrm;
    logic [4:0]  InTag;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutRes;
    logic [4:0]  OutFlg;
    logic [4:0]  OutTag;
    logic        FlgClr;
    logic [4:0]  AccFlg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fround_pipe #(.NE(8), .NF(23), .MW(32), .TAGW(5)) dut (
        .clk(clk), .resetn(resetn), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .InS(InS), .InE(InE), .InM(InM), .InSticky(InSticky), .InKind(InKind),
        .InNV(InNV), .InDZ(InDZ), .InFrm(InFrm), .InTag(InTag),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutRes(OutRes), .OutFlg(OutFlg), .OutTag(OutTag),
        .FlgClr(FlgClr), .AccFlg(AccFlg)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input int e, input logic [31:0] m, input logic [2:0] frm,
                         input logic sticky, input logic [1:0] kind, input logic [1:0] nvdz,
                         input logic [4:0] tag);
        InValid  = 1'b1;
        InS      = s;
        InE      = 10'(e);
        InM      = m;
        InFrm    = frm;
        InSticky = sticky;
        InKind   = kind;
        InNV     = nvdz[1];
        InDZ     = nvdz[0];
        InTag    = tag;
    endtask

    // One op through an idle pipeline with OutReady=1: also checks the 2-cycle latency.
    task automatic runOne(input string name, input logic s, input int e, input logic [31:0] m,
                          input logic [2:0] frm, input logic sticky, input logic [1:0] kind,
                          input logic [1:0] nvdz, input logic [4:0] tag,
                          input logic [31:0] expRes, input logic [4:0] expFlg);
        @(negedge clk);
        drive(s, e, m, frm, sticky, kind, nvdz, tag);
        #1 check({name, "/inready"}, 32'(InReady), 32'd1);
        @(negedge clk);
        InValid = 1'b0;
        check({name, "/lat1"}, 32'(OutValid), 32'd0);
        @(negedge clk);
        check({name, "/valid"}, 32'(OutValid), 32'd1);
        check({name, "/res"}, OutRes, expRes);
        check({name, "/flg"}, 32'(OutFlg), 32'(expFlg));
        check({name, "/tag"}, 32'(OutTag), 32'(tag));
        $display("[TB] %s: res=%h flg=%h tag=%0d", name, OutRes, OutFlg, OutTag);
    endtask

    initial begin
        resetn = 1'b0; Flush = 1'b0; FlgClr = 1'b0; OutReady = 1'b1;
        InValid = 1'b0; InS = 1'b0; InE = '0; InM = '0; InSticky = 1'b0;
        InKind = 2'b00; InNV = 1'b0; InDZ = 1'b0; InFrm = RNE; InTag = '0;
        repeat (3) @(negedge clk);
        check("rst/outvalid", 32'(OutValid), 32'd0);
        check("rst/res", OutRes, 32'h0);
        check("rst/flg", 32'(OutFlg), 32'd0);
        check("rst/tag", 32'(OutTag), 32'd0);
        check("rst/acc", 32'(AccFlg), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("rst/inready", 32'(InReady), 32'd1);
        $display("[TB] reset released");

        runOne("one",        0, 127, 32'h80000000, RNE, 0, 2'b00, 2'b00, 5'd1,  32'h3F800000, 5'h00);
        runOne("tie_rne",    0, 127, 32'h80000080, RNE, 0, 2'b00, 2'b00, 5'd2,  32'h3F800000, 5'h01);
        runOne("tie_rup",    0, 127, 32'h80000080, RUP, 0, 2'b00, 2'b00, 5'd3,  32'h3F800001, 5'h01);
        runOne("tie_rmm",    0, 127, 32'h80000080, RMM, 0, 2'b00, 2'b00, 5'd4,  32'h3F800001, 5'h01);
        runOne("ovf_rne",    0, 255, 32'h80000000, RNE, 0, 2'b00, 2'b00, 5'd5,  32'h7F800000, 5'h05);
        runOne("ovf_rtz",    0, 255, 32'h80000000, RTZ, 0, 2'b00, 2'b00, 5'd6,  32'h7F7FFFFF, 5'h05);
        runOne("ovf_neg_rdn",1, 255, 32'h80000000, RDN, 0, 2'b00, 2'b00, 5'd7,  32'hFF800000, 5'h05);
        runOne("ovf_neg_rup",1, 255, 32'h80000000, RUP, 0, 2'b00, 2'b00, 5'd8,  32'hFF7FFFFF, 5'h05);
        runOne("sub_exact",  0, 0,   32'h80000000, RNE, 0, 2'b00, 2'b00, 5'd9,  32'h00400000, 5'h00);
        runOne("sub_sticky", 0, 0,   32'h80000000, RNE, 1, 2'b00, 2'b00, 5'd10, 32'h00400000, 5'h03);
        runOne("lzc31",      0, 158, 32'h00000001, RNE, 0, 2'b00, 2'b00, 5'd11, 32'h3F800000, 5'h00);
        runOne("mant_carry", 0, 127, 32'hFFFFFF80, RNE, 0, 2'b00, 2'b00, 5'd12, 32'h40000000, 5'h01);
        runOne("sub_to_norm",0, 0,   32'hFFFFFF80, RNE, 0, 2'b00, 2'b00, 5'd13, 32'h00800000, 5'h01);
        runOne("sub_rtz",    0, 0,   32'hFFFFFF80, RTZ, 0, 2'b00, 2'b00, 5'd14, 32'h007FFFFF, 5'h03);
        runOne("clip_rup",   0, -100,32'h80000000, RUP, 0, 2'b00, 2'b00, 5'd15, 32'h00000001, 5'h03);
        runOne("nan_nv",     1, 127, 32'h80000080, RNE, 1, 2'b11, 2'b10, 5'd16, 32'h7FC00000, 5'h10);
        runOne("zero_neg",   1, 127, 32'h80000080, RNE, 1, 2'b01, 2'b00, 5'd17, 32'h80000000, 5'h00);
        runOne("inf_dz",     1, 127, 32'h80000000, RNE, 0, 2'b10, 2'b01, 5'd18, 32'hFF800000, 5'h08);

        // FlgClr with no transfer empties the accumulator.
        @(negedge clk);
        FlgClr = 1'b1;
        @(negedge clk);
        FlgClr = 1'b0;
        check("acc/clr_alone", 32'(AccFlg), 32'd0);
        $display("[TB] acc clear: acc=%h", AccFlg);

        // Backpressure: tags 1 (overflow), 2 (inexact), 3 (exact) offered while stalled.
        OutReady = 1'b0;
        @(negedge clk);
        drive(0, 255, 32'h80000000, RNE, 0, 2'b00, 2'b00, 5'd1);
        #1 check("bp/ready1", 32'(InReady), 32'd1);
        @(negedge clk);
        drive(0, 127, 32'h80000080, RNE, 0, 2'b00, 2'b00, 5'd2);
        #1 check("bp/ready2", 32'(InReady), 32'd1);
        @(negedge clk);
        drive(0, 127, 32'h80000000, RNE, 0, 2'b00, 2'b00, 5'd3);
        #1 check("bp/ready3", 32'(InReady), 32'd0);
        check("bp/tag1_valid", 32'(OutValid), 32'd1);
        check("bp/tag1_tag", 32'(OutTag), 32'd1);
        @(negedge clk);
        check("bp/hold_ready", 32'(InReady), 32'd0);
        check("bp/hold_tag", 32'(OutTag), 32'd1);
        check("bp/hold_res", OutRes, 32'h7F800000);
        $display("[TB] stall: tag=%0d res=%h ready=%0d", OutTag, OutRes, InReady);
        @(negedge clk);
        OutReady = 1'b1;
        #1 check("bp/release_ready", 32'(InReady), 32'd1);
        @(negedge clk);
        InValid = 1'b0;
        check("bp/out2_tag", 32'(OutTag), 32'd2);
        check("bp/out2_flg", 32'(OutFlg), 32'h01);
        check("bp/acc_after1", 32'(AccFlg), 32'h05);
        $display("[TB] out tag=%0d flg=%h acc=%h", OutTag, OutFlg, AccFlg);
        FlgClr = 1'b1;
        @(negedge clk);
        FlgClr = 1'b0;
        check("bp/out3_tag", 32'(OutTag), 32'd3);
        check("bp/out3_res", OutRes, 32'h3F800000);
        check("bp/acc_clr_xfer", 32'(AccFlg), 32'h01);
        $display("[TB] out tag=%0d res=%h acc=%h", OutTag, OutRes, AccFlg);
        @(negedge clk);
        check("bp/drained", 32'(OutValid), 32'd0);
        check("bp/acc_after3", 32'(AccFlg), 32'h01);

        // Flush with two ops in flight plus one offered in the flush cycle.
        OutReady = 1'b0;
        @(negedge clk);
        drive(0, 127, 32'h80000080, RUP, 0, 2'b00, 2'b00, 5'd4);
        @(negedge clk);
        drive(0, 255, 32'h80000000, RNE, 0, 2'b00, 2'b00, 5'd5);
        @(negedge clk);
        drive(0, 127, 32'h80000000, RNE, 0, 2'b00, 2'b00, 5'd6);
        check("fl/full_valid", 32'(OutValid), 32'd1);
        #1 check("fl/full_ready", 32'(InReady), 32'd0);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        InValid = 1'b0;
        check("fl/no_valid", 32'(OutValid), 32'd0);
        check("fl/ready", 32'(InReady), 32'd1);
        check("fl/acc_kept", 32'(AccFlg), 32'h01);
        $display("[TB] flush: valid=%0d acc=%h", OutValid, AccFlg);
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fl/stays_empty", 32'(OutValid), 32'd0);
        end
        check("fl/acc_end", 32'(AccFlg), 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
